// File: rtl/bullet_if.sv
// bullet_if: scan position, ship reference and player inputs to the bullet,
// plus the bullet's registered position and colour layer back out.
interface bullet_if;
   logic        video_on;
   logic [10:0] pix_x, pix_y;
   logic [10:0] ship_x, ship_y;
   logic        fire, hit;
   logic [10:0] bull_x, bull_y;
   logic        bull_on;
   logic [2:0]  rgb;
   logic        bull_active;
   modport master (
      output video_on, pix_x, pix_y, ship_x, ship_y, fire, hit,
      input  bull_x, bull_y, bull_on, rgb, bull_active
   );
   modport slave (
      input  video_on, pix_x, pix_y, ship_x, ship_y, fire, hit,
      output bull_x, bull_y, bull_on, rgb, bull_active
   );
endinterface

// File: rtl/bullet.sv
// bullet: player bullet launched from the ship nose, climbing once per frame, parked off-screen when idle.
// Define BULLET_COOLDOWN_EN to add a COOL_FRAMES-tick cooldown after every flight.
module bullet #(
   parameter int BULL_V      = 4,
   parameter int BULL_W      = 2,
   parameter int BULL_H      = 6,
   parameter int COOL_FRAMES = 8
) (
   input logic     clk,
   input logic     reset,
   bullet_if.slave b
);
   localparam logic [10:0] PARK = 11'd2047;
`ifdef BULLET_COOLDOWN_EN
   typedef enum logic [1:0] {IDLE, FLY, COOL} state_t;
   logic [3:0] cool_cnt;
`else
   typedef enum logic {IDLE, FLY} state_t;
`endif
   state_t      state;
   logic        fire_d, fire_edge, frame_tick, leave;
   logic [10:0] bull_x, bull_y, x_end, y_end;
   assign frame_tick = b.pix_y == 11'd481 && b.pix_x == 11'd0;
   assign fire_edge  = b.fire & ~fire_d;
   // hit wins over a same-cycle frame tick, so a hit bullet never moves first
   assign leave      = b.hit || (frame_tick && bull_y < 11'(BULL_V));
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         bull_x <= PARK;
         bull_y <= PARK;
         fire_d <= 1'b1;
`ifdef BULLET_COOLDOWN_EN
         cool_cnt <= 4'd0;
`endif
      end else begin
         fire_d <= b.fire;
         case (state)
            IDLE: if (fire_edge) begin
               state  <= FLY;
               bull_x <= b.ship_x;
               bull_y <= b.ship_y < 11'(BULL_H) ? 11'd0 : b.ship_y - 11'(BULL_H);
            end
            FLY: if (leave) begin
`ifdef BULLET_COOLDOWN_EN
               state    <= COOL;
               cool_cnt <= 4'(COOL_FRAMES);
`else
               state    <= IDLE;
`endif
               bull_x <= PARK;
               bull_y <= PARK;
            end else if (frame_tick) bull_y <= bull_y - 11'(BULL_V);
`ifdef BULLET_COOLDOWN_EN
            COOL: if (frame_tick) begin
               cool_cnt <= cool_cnt - 4'd1;
               if (cool_cnt == 4'd1) state <= IDLE;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end
   assign x_end         = bull_x + 11'(BULL_W - 1);
   assign y_end         = bull_y + 11'(BULL_H - 1);
   assign b.bull_x      = bull_x;
   assign b.bull_y      = bull_y;
   assign b.bull_active = state == FLY;
   assign b.bull_on     = b.bull_active && b.pix_x >= bull_x && b.pix_x <= x_end &&
                          b.pix_y >= bull_y && b.pix_y <= y_end;
   assign b.rgb         = b.video_on && b.bull_on ? 3'b110 : 3'b000;
endmodule

// File: tb/tb_bullet.sv
// tb_bullet: directed scenarios plus randomized play against a frame-level bullet model.
module tb_bullet;
   localparam int V = 4, W = 2, H = 6, CF = 8;
`ifdef BULLET_COOLDOWN_EN
   localparam bit COOL_EN = 1'b1;
`else
   localparam bit COOL_EN = 1'b0;
`endif
   logic clk = 1'b0;
   logic reset;
   bullet_if bif();
   bullet dut (.clk(clk), .reset(reset), .b(bif));
   always #5 clk = ~clk;
   int n_checks = 0, n_errors = 0;
   int m_x = 2047, m_y = 2047, m_cool = 0;
   bit m_active = 1'b0, m_fire_d = 1'b1;
   task automatic check(input string n, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", n, act, exp, $time);
      end
   endtask
   // model: a bullet is either flying at (m_x,m_y), cooling for m_cool more frames, or ready
   always @(posedge clk) begin : model
      int nx, ny, nc;
      bit na, tick, press;
      nx = m_x; ny = m_y; nc = m_cool; na = m_active;
      tick  = bif.pix_y == 11'd481 && bif.pix_x == 11'd0;
      press = bif.fire && !m_fire_d;
      if (reset) begin
         na = 0; nx = 2047; ny = 2047; nc = 0;
      end else if (m_active) begin
         if (bif.hit || (tick && m_y < V)) begin
            na = 0; nx = 2047; ny = 2047; nc = COOL_EN ? CF : 0;
         end else if (tick) ny = m_y - V;
      end else if (m_cool > 0) begin
         if (tick) nc = m_cool - 1;
      end else if (press) begin
         na = 1; nx = int'(bif.ship_x); ny = bif.ship_y < H ? 0 : int'(bif.ship_y) - H;
      end
      m_active <= na; m_x <= nx; m_y <= ny; m_cool <= nc;
      m_fire_d <= reset ? 1'b1 : bif.fire;
   end
   always @(negedge clk) begin : compare
      bit on;
      on = m_active && int'(bif.pix_x) >= m_x && int'(bif.pix_x) <= m_x + W - 1 &&
           int'(bif.pix_y) >= m_y && int'(bif.pix_y) <= m_y + H - 1;
      check("bull_x", int'(bif.bull_x), m_x);
      check("bull_y", int'(bif.bull_y), m_y);
      check("bull_active", int'(bif.bull_active), int'(m_active));
      check("bull_on", int'(bif.bull_on), int'(on));
      check("rgb", int'(bif.rgb), (bif.video_on && on) ? 6 : 0);
   end
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic frame();
      bif.pix_x = 11'd0; bif.pix_y = 11'd481; step(1);
      bif.pix_y = 11'd0; step(1);
   endtask
   task automatic launch(input int x, input int y);
      bif.fire = 1'b0; bif.ship_x = 11'(x); bif.ship_y = 11'(y); step(1);
      bif.fire = 1'b1; step(1);
      bif.fire = 1'b0;
   endtask
   task automatic cool_wait();
      if (COOL_EN) repeat (CF) frame();
   endtask
   task automatic kill();
      bif.hit = 1'b1; step(1); bif.hit = 1'b0;
      check("kill_parked", int'(bif.bull_y), 2047);
      cool_wait();
   endtask
   initial begin
      reset = 1'b1;
      bif.video_on = 1'b0; bif.pix_x = 11'd0; bif.pix_y = 11'd0;
      bif.ship_x = 11'd0; bif.ship_y = 11'd0; bif.fire = 1'b1; bif.hit = 1'b0;
      step(2);
      reset = 1'b0; step(1);
      check("reset_active", int'(bif.bull_active), 0);
      check("reset_x", int'(bif.bull_x), 2047);
      check("reset_y", int'(bif.bull_y), 2047);
      step(3);
      check("held_fire_no_launch", int'(bif.bull_active), 0);
      launch(100, 400);
      check("launch_active", int'(bif.bull_active), 1);
      check("launch_x", int'(bif.bull_x), 100);
      check("launch_y", int'(bif.bull_y), 394);
      repeat (10) frame();
      check("ten_frames_y", int'(bif.bull_y), 354);
      check("ten_frames_x", int'(bif.bull_x), 100);
      bif.ship_x = 11'd500; bif.fire = 1'b1; step(1); bif.fire = 1'b0; step(1);
      check("refire_ignored_x", int'(bif.bull_x), 100);
      check("refire_ignored_y", int'(bif.bull_y), 354);
      kill();
      launch(50, 9);
      check("low_launch_y", int'(bif.bull_y), 3);
      frame();
      check("exit_top_active", int'(bif.bull_active), 0);
      check("exit_top_x", int'(bif.bull_x), 2047);
      check("exit_top_y", int'(bif.bull_y), 2047);
      cool_wait();
      launch(60, 106);
      check("y100", int'(bif.bull_y), 100);
      bif.hit = 1'b1; bif.pix_x = 11'd0; bif.pix_y = 11'd481; step(1);
      bif.hit = 1'b0; bif.pix_y = 11'd0;
      check("hit_tick_active", int'(bif.bull_active), 0);
      check("hit_tick_y", int'(bif.bull_y), 2047);
      cool_wait();
      launch(70, 300);
      bif.hit = 1'b1; step(1); bif.hit = 1'b0;
      if (COOL_EN) begin
         repeat (5) frame();
         bif.fire = 1'b1; step(1); bif.fire = 1'b0; step(1);
         check("cool_fire_ignored", int'(bif.bull_active), 0);
         repeat (3) frame();
      end
      bif.fire = 1'b1; step(1); bif.fire = 1'b0;
      check("relaunch_active", int'(bif.bull_active), 1);
      check("relaunch_y", int'(bif.bull_y), 294);
      kill();
      launch(10, 3);
      check("saturate_y", int'(bif.bull_y), 0);
      kill();
      launch(320, 206);
      check("pix_base_y", int'(bif.bull_y), 200);
      bif.video_on = 1'b1; bif.pix_x = 11'd321; bif.pix_y = 11'd205; #1;
      check("rgb_inside", int'(bif.rgb), 6);
      bif.pix_x = 11'd322; #1;
      check("rgb_right_edge", int'(bif.rgb), 0);
      bif.pix_x = 11'd321; bif.video_on = 1'b0; #1;
      check("rgb_blank", int'(bif.rgb), 0);
      reset = 1'b1; step(1); reset = 1'b0;
      check("reset_midfly", int'(bif.bull_active), 0);
      for (int i = 0; i < 4000; i++) begin
         reset = $urandom_range(0, 299) == 0;
         if ($urandom_range(0, 9) == 0) bif.fire = ~bif.fire;
         bif.hit = $urandom_range(0, 39) == 0;
         bif.video_on = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) begin
            bif.pix_x = 11'd0; bif.pix_y = 11'd481;
         end else begin
            bif.pix_x = 11'(m_x + int'($urandom_range(0, 3)) - 1);
            bif.pix_y = 11'(m_y + int'($urandom_range(0, 8)) - 1);
         end
         if ($urandom_range(0, 7) == 0) begin
            bif.ship_x = 11'($urandom_range(0, 1500));
            bif.ship_y = 11'($urandom_range(0, 1) ? $urandom_range(0, 10) : $urandom_range(0, 600));
         end
         step(1);
      end
      reset = 1'b1; step(1); reset = 1'b0;
      check("final_reset_active", int'(bif.bull_active), 0);
      check("final_reset_x", int'(bif.bull_x), 2047);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
